// File: rtl/sntc_ldpc_enc_pkg.sv
// Shared definitions for the systematic LDPC encoder: code dimensions,
// the message-part parity matrix Hs and the encoder FSM state type.
package sntc_ldpc_enc_pkg;

  localparam int ENC_MM = 168;
  localparam int ENC_NN = 208;
  localparam int ENC_KK = ENC_NN - ENC_MM;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ENC  = 2'd1,
    ST_DONE = 2'd2
  } enc_state_t;

  // Deterministic pseudo-random sparse Hs, shared with the decoder side.
  // Each entry is a hashed function of (row, column) so the matrix can be
  // regenerated anywhere without a large literal table.
  function automatic logic [ENC_MM-1:0][ENC_KK-1:0] gen_hs_rows();
    logic [ENC_MM-1:0][ENC_KK-1:0] rows;
    logic [31:0]                   h;
    rows = '0;
    for (int r = 0; r < ENC_MM; r++) begin
      for (int k = 0; k < ENC_KK; k++) begin
        h          = 32'(r * 64 + k + 1) * 32'h9E37_79B1;
        h          = h ^ (h >> 15);
        rows[r][k] = h[11] & h[23];
      end
    end
    return rows;
  endfunction

  // Row r of Hs is HS_ROWS[r]; bit k multiplies message bit k.
  localparam logic [ENC_MM-1:0][ENC_KK-1:0] HS_ROWS = gen_hs_rows();

endpackage

// File: rtl/sntc_ldpc_hs_rom.sv
// Combinational Hs lookup: returns PAR_PER_CYC consecutive rows starting
// at row_idx. Keeps the matrix source in one place (the package).
module sntc_ldpc_hs_rom
  import sntc_ldpc_enc_pkg::*;
#(
  parameter int MM          = ENC_MM,
  parameter int KK          = ENC_KK,
  parameter int PAR_PER_CYC = 1,
  parameter int CNT_W       = $clog2(MM)
) (
  input  logic [CNT_W-1:0]                 row_idx,
  output logic [PAR_PER_CYC-1:0][KK-1:0]  rows
);

  // One lookup per parity bit resolved in the current step.
  for (genvar gi = 0; gi < PAR_PER_CYC; gi++) begin : g_row
    logic [CNT_W-1:0] r;
    assign r        = row_idx + CNT_W'(gi);
    assign rows[gi] = HS_ROWS[r];
  end

endmodule

// File: rtl/sntc_ldpc_encoder.sv
// Systematic LDPC encoder for H = [Hs | T] with T dual-diagonal.
// Parity bits are resolved serially, PAR_PER_CYC per clock, so that the
// produced codeword c satisfies H*c = tgt_syn over GF(2).
module sntc_ldpc_encoder
  import sntc_ldpc_enc_pkg::*;
#(
  parameter int  MM          = ENC_MM,
  parameter int  NN          = ENC_NN,
  parameter int  PAR_PER_CYC = 1,
  parameter int  CNT_W       = $clog2(MM),
  localparam int KK          = NN - MM
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          clr,
  input  logic          start,
  output logic          in_ready,
  input  logic [KK-1:0] msg_in,
  input  logic [MM-1:0] tgt_syn,
  output logic          valid,
  input  logic          out_ready,
  output logic [NN-1:0] cword_out,
  output logic          busy
);

  // Step size must tile the parity vector exactly, and the matrix in the
  // package is only defined for the package dimensions.
  if ((MM % PAR_PER_CYC) != 0 || MM != ENC_MM || NN != ENC_NN) begin : g_param_check
    $error("sntc_ldpc_encoder: PAR_PER_CYC must divide MM and MM/NN must match the Hs source");
  end

  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(MM - PAR_PER_CYC);
  localparam logic [CNT_W-1:0] STEP     = CNT_W'(PAR_PER_CYC);

  enc_state_t        state_reg;
  logic [CNT_W-1:0]  row_cnt_reg;
  logic              acc_reg;
  logic [KK-1:0]     msg_reg;
  logic [MM-1:0]     syn_reg;
  logic [MM-1:0]     par_reg;
  logic              valid_reg;
  logic              busy_reg;
  logic              in_ready_reg;

  logic [PAR_PER_CYC-1:0][KK-1:0] hs_rows;
  logic [PAR_PER_CYC-1:0]         syn_slice;
  logic [PAR_PER_CYC-1:0]         p_vec;
  logic [PAR_PER_CYC:0]           acc_chain;

  sntc_ldpc_hs_rom #(
    .MM          (MM),
    .KK          (KK),
    .PAR_PER_CYC (PAR_PER_CYC),
    .CNT_W       (CNT_W)
  ) u_hs_rom (
    .row_idx (row_cnt_reg),
    .rows    (hs_rows)
  );

  assign syn_slice    = syn_reg[row_cnt_reg +: PAR_PER_CYC];
  assign acc_chain[0] = acc_reg;

  // Staircase recursion: p[r] = p[r-1] ^ (Hs_row(r) . msg) ^ syn[r],
  // chained across the bits resolved in one step.
  for (genvar gi = 0; gi < PAR_PER_CYC; gi++) begin : g_par
    assign p_vec[gi]       = acc_chain[gi] ^ (^(hs_rows[gi] & msg_reg)) ^ syn_slice[gi];
    assign acc_chain[gi+1] = p_vec[gi];
  end

  // Encoder FSM with registered handshake outputs; clr acts as a reset.
  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      state_reg    <= ST_IDLE;
      row_cnt_reg  <= '0;
      acc_reg      <= 1'b0;
      msg_reg      <= '0;
      syn_reg      <= '0;
      par_reg      <= '0;
      valid_reg    <= 1'b0;
      busy_reg     <= 1'b0;
      in_ready_reg <= 1'b1;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            msg_reg      <= msg_in;
            syn_reg      <= tgt_syn;
            row_cnt_reg  <= '0;
            acc_reg      <= 1'b0;
            state_reg    <= ST_ENC;
            busy_reg     <= 1'b1;
            in_ready_reg <= 1'b0;
          end
        end
        ST_ENC: begin
          par_reg[row_cnt_reg +: PAR_PER_CYC] <= p_vec;
          acc_reg <= p_vec[PAR_PER_CYC-1];
          if (row_cnt_reg == LAST_ROW) begin
            state_reg <= ST_DONE;
            valid_reg <= 1'b1;
          end else begin
            row_cnt_reg <= row_cnt_reg + STEP;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            state_reg    <= ST_IDLE;
            valid_reg    <= 1'b0;
            busy_reg     <= 1'b0;
            in_ready_reg <= 1'b1;
          end
        end
        default: begin
          state_reg    <= ST_IDLE;
          valid_reg    <= 1'b0;
          busy_reg     <= 1'b0;
          in_ready_reg <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_reg;
  assign valid     = valid_reg;
  assign busy      = busy_reg;
  assign cword_out = {par_reg, msg_reg};

endmodule
